// File: rtl/piso_frame_serializer.sv
// Parallel-in serial-out framer: start bit, LSB-first payload, optional parity, stop bit.
// serial_out is registered; in_ready is high in IDLE and STOP so frames can stream back to back.
module piso_frame_serializer #(
  parameter int DATA_WIDTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par;
  logic                  so_nx;
  logic                  accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_START;
      end
      S_START: begin
        busy     = 1'b1;
        state_nx = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (cnt == CW'(DATA_WIDTH - 1))
          state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        busy     = 1'b1;
        state_nx = S_STOP;
      end
      S_STOP: begin
        in_ready   = 1'b1;
        frame_done = 1'b1;
        state_nx   = in_valid ? S_START : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // The line flop is loaded from the state being entered, so it lines up with that state.
  always_comb begin
    so_nx = 1'b1;
    case (state_nx)
      S_START:  so_nx = 1'b0;
      S_DATA:   so_nx = shreg[0];
      S_PARITY: so_nx = par;
      default:  so_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      serial_out <= 1'b1;
      shreg      <= '0;
      cnt        <= '0;
      par        <= 1'b0;
    end else begin
      state      <= state_nx;
      serial_out <= so_nx;
      if (accept) begin
        shreg <= in_data;
        par   <= (^in_data) ^ (PARITY_ODD != 0);
        cnt   <= '0;
      end else if (state_nx == S_DATA) begin
        // Each DATA-bound edge consumes the LSB just placed on the line.
        shreg <= shreg >> 1;
        if (state == S_DATA) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Bench for piso_frame_serializer: queued frame model for the default build, directed checks for parity variants.
module tb_piso_frame_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       r0, so0, b0, d0;
  logic       r1, so1, b1, d1;
  logic       r2, so2, b2, d2;

  always #5 clk = ~clk;

  piso_frame_serializer #(.DATA_WIDTH(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v0), .in_ready(r0),
    .serial_out(so0), .busy(b0), .frame_done(d0));

  piso_frame_serializer #(.DATA_WIDTH(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v1), .in_ready(r1),
    .serial_out(so1), .busy(b1), .frame_done(d1));

  piso_frame_serializer #(.DATA_WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(v2), .in_ready(r2),
    .serial_out(so2), .busy(b2), .frame_done(d2));

  typedef struct packed {
    logic so;
    logic busy;
    logic done;
    logic rdy;
  } item_t;

  item_t q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    acc    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Bit idx of a frame: start, payload LSB first, optional parity, then stop/idle ones.
  function automatic logic frame_bit(input logic [3:0] d, input bit pen, input bit podd, input int idx);
    logic p;
    p = ((d[0] + d[1] + d[2] + d[3]) % 2 == 1) ^ podd;
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 4) return d[idx-1];
    if (idx == 5 && pen) return p;
    return 1'b1;
  endfunction

  // Reference model: the block is ready whenever nothing of the current frame remains queued.
  always @(posedge clk or posedge rst) begin
    acc = 1'b0;
    if (rst) q.delete();
    else if (v0 && q.size() == 0) begin
      acc = 1'b1;
      for (int i = 0; i < 7; i++) begin
        item_t it;
        it.so   = frame_bit(in_data, 1'b1, 1'b0, i);
        it.busy = (i < 6);
        it.done = (i == 6);
        it.rdy  = (i == 6);
        q.push_back(it);
      end
    end
  end

  always @(negedge clk) begin
    item_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = 4'b1001;
    chk("line", {28'h0, so0, b0, d0, r0}, {28'h0, e});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    v0 = 1'b1;
    in_data = d;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (acc) break;
    end
    chk("accept", {31'h0, acc}, 32'h1);
    v0 = 1'b0;
  endtask

  task automatic stream(input int n);
    int got = 0;
    v0 = 1'b1;
    for (int t = 0; t < 200 && got < n; t++) begin
      in_data = 4'($urandom);
      tick();
      if (acc) got++;
    end
    chk("stream", got, n);
    v0 = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_so", {31'h0, so0}, 32'h1);
    chk("rst_busy", {31'h0, b0}, 32'h0);
    chk("rst_done", {31'h0, d0}, 32'h0);
    chk("rst_rdy", {31'h0, r0}, 32'h1);
    rst = 1'b0;

    repeat (20) tick();

    send(4'b1011);
    repeat (10) tick();

    send(4'hA);
    send(4'h5);
    repeat (10) tick();

    stream(4);
    repeat (10) tick();

    // Abort during payload bit 2
    send(4'h6);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("abort_so", {31'h0, so0}, 32'h1);
    chk("abort_busy", {31'h0, b0}, 32'h0);
    chk("abort_rdy", {31'h0, r0}, 32'h1);
    chk("abort_done", {31'h0, d0}, 32'h0);
    tick();
    rst = 1'b0;
    send(4'h9);
    repeat (10) tick();

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(4'($urandom));
    end
    repeat (10) tick();

    in_data = 4'b1011;
    v1 = 1'b1;
    v2 = 1'b1;
    tick();
    v1 = 1'b0;
    v2 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("odd_so", {31'h0, so1}, {31'h0, frame_bit(4'b1011, 1'b1, 1'b1, c)});
      chk("odd_done", {31'h0, d1}, {31'h0, c == 6});
      chk("odd_busy", {31'h0, b1}, {31'h0, c < 6});
      chk("odd_rdy", {31'h0, r1}, {31'h0, c == 6});
      chk("np_so", {31'h0, so2}, {31'h0, frame_bit(4'b1011, 1'b0, 1'b0, c)});
      chk("np_done", {31'h0, d2}, {31'h0, c == 5});
      chk("np_busy", {31'h0, b2}, {31'h0, c < 5});
      chk("np_rdy", {31'h0, r2}, {31'h0, c >= 5});
      tick();
    end

    repeat (12) tick();
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_frame_serializer.md
PISO_FRAME_SERIALIZER -- requirements
Module: piso_frame_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 4: payload width in bits, legal values 2 to 32.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts a parity bit after the payload, 0 omits it.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH  parallel word offered by the upstream source.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 serial_out  output  1  registered serial line that feeds the downstream serial-in serial-out shift register.
REQ-010 busy  output  1  high while any frame bit other than idle is on serial_out.
REQ-011 frame_done  output  1  one-cycle pulse that is high during the stop bit.

Function
REQ-012 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured into an internal shift register on that edge.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
- REQ-014 Transitions SHALL be:
  - IDLE to START on accept.
  - START to DATA after 1 cycle.
  - DATA to PARITY after DATA_WIDTH cycles, or DATA to STOP if PARITY_EN=0.
  - PARITY to STOP after 1 cycle.
  - STOP to START on accept, otherwise STOP to IDLE.
REQ-015 serial_out SHALL be 1 in IDLE, 0 in START, the current shift-register LSB in DATA (bits sent LSB first), the parity bit in PARITY, and 1 in STOP.
REQ-016 serial_out SHALL come from a flop; for an accept at edge k, the start bit SHALL appear in cycle k+1 and data bit i in cycle k+2+i.
REQ-017 The frame length SHALL be DATA_WIDTH+2+PARITY_EN cycles.
REQ-018 The parity bit SHALL be the XOR of all captured data bits, inverted when PARITY_ODD=1.
REQ-019 Parity SHALL be computed from the captured word, not from live in_data.
REQ-020 in_ready SHALL be 1 in IDLE and STOP and 0 in START, DATA and PARITY.
REQ-021 Changes on in_data or in_valid while in_ready=0 SHALL have no effect on the frame in flight.
REQ-022 An accept during STOP SHALL start the next frame in the following cycle with no idle gap, so back-to-back frames stream continuously.
REQ-023 busy SHALL be 1 in START, DATA and PARITY, and 0 in IDLE and STOP.
REQ-024 frame_done SHALL be 1 exactly in the STOP cycle of each frame, including STOP cycles of back-to-back frames.
REQ-025 A DATA-bit counter SHALL count 0 to DATA_WIDTH-1 with width clog2(DATA_WIDTH), and SHALL clear on entry to START.
REQ-026 in_valid=1 in IDLE with no reset active SHALL always be accepted; there is no condition under which the block is not ready in IDLE.

Reset
REQ-027 While rst=1 the state SHALL be IDLE, with serial_out=1, busy=0, frame_done=0, in_ready=1, and the shift register and counter at 0.
REQ-028 rst SHALL act immediately without waiting for a clock edge, and SHALL abort a frame in progress with no partial completion.
REQ-029 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (DATA_WIDTH=4)
REQ-030 Single frame, PARITY_EN=1, PARITY_ODD=0: accept in_data=4'b1011 -> serial_out over 7 cycles = 0,1,1,0,1,1,1, with frame_done high on the 7th cycle.
REQ-031 Back-to-back frames: accept 4'hA, then 4'h5 during STOP -> 0,0,1,0,1,0,1 followed immediately by 0,1,0,1,0,0,1, with no idle cycle between them.
REQ-032 Hold while busy: in_valid stays 1 and in_data changes every cycle during a frame -> in_ready=0, the transmitted bits match the captured word, and the next word is accepted only in STOP.
REQ-033 Reset mid-frame: assert rst during DATA bit 2 -> serial_out=1, busy=0 and in_ready=1 without waiting for a clock edge; the next accept produces a full, correct frame.
REQ-034 Parameter builds:
- PARITY_ODD=1 with 4'b1011 -> parity bit 0.
- PARITY_EN=0 with 4'b1011 -> 6-cycle frame 0,1,1,0,1,1.
REQ-035 Idle: no in_valid for 20 cycles after reset -> serial_out=1, busy=0 and frame_done=0 throughout.
